mem_burst_master: RTL
=====================

# mem_burst_master

Burst initiator for the on-chip single-port SRAM request/response interface (addr/data/mask/we/valid out, data/resp in). Accepts one burst command (base address, beat count, direction), issues one memory request per beat with incrementing word address, and moves data between the SRAM and valid/ready write-data and read-data streams. It sits between DMA/loader logic and an SRAM instance. It works with either SRAM read latency: combinational, where resp arrives in the same cycle, or pipelined, where resp arrives in the next cycle.

## Interface
- SIZE, 1024: target memory size in bytes.
- DATAW, 32: data width.
- LENW, 8: burst-length field width.
- FIFO_DEPTH, 2: read-response buffer entries, ≥2.
- ADDRW, $clog2(SIZE): byte address width.
- MASKW, DATAW/8: byte-mask width.

Clock and reset are fixed: one clock; reset is asynchronous and active-low.
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous, active-low reset.

Command port:
- cmd_valid_i  in  1  command request.
- cmd_ready_o  out  1  high only in IDLE.
- cmd_we_i  in  1  1 = write burst, 0 = read burst.
- cmd_addr_i  in  ADDRW  base byte address; low $clog2(MASKW) bits ignored.
- cmd_len_i  in  LENW  beat count.

Write-data stream:
- wdata_i  in  DATAW  write data.
- wmask_i  in  MASKW  byte mask.
- wvalid_i  in  1  write beat valid.
- wready_o  out  1  write beat accepted.

Read-data stream:
- rdata_o  out  DATAW  head of the response FIFO.
- rvalid_o  out  1  FIFO not empty.
- rready_i  in  1  consumer pop.

Memory port:
- mem_addr_o  out  ADDRW  request address.
- mem_data_o  out  DATAW  write data.
- mem_mask_o  out  MASKW  byte mask.
- mem_we_o  out  1  write enable.
- mem_valid_o  out  1  request valid.
- mem_data_i  in  DATAW  read data.
- mem_resp_i  in  1  response.

Status:
- done_o  out  1  one-cycle pulse when a burst completes.
- err_o  out  1  sticky flag: spurious response seen.

## Operation
- States: IDLE, WRITE, READ, DRAIN.
- IDLE: a command is accepted on cmd_valid_i && cmd_ready_o, which latches base, len and we.
  - len == 0: stay in IDLE, pulse done_o next cycle, no memory traffic.
  - Otherwise go to WRITE or READ.
- WRITE:
  - wready_o = 1.
  - mem_valid_o = wvalid_i (combinational pass-through), mem_we_o = 1, mem_data_o/mem_mask_o = wdata_i/wmask_i.
  - Each accepted beat: address += MASKW, remaining -= 1, outstanding += 1.
- READ:
  - mem_valid_o = 1 while remaining > 0 and outstanding + fifo_count < FIFO_DEPTH.
  - mem_we_o = 0, mem_mask_o = 0.
- Every mem_resp_i decrements outstanding. In a read burst, mem_data_i is also pushed into the FIFO.
- Credit rule: the SRAM cannot stall, so a read is issued only if its response slot is already reserved. The FIFO never overflows.
- After the last beat is issued, go to DRAIN.
- DRAIN: wait for outstanding == 0 (and, for reads, FIFO empty). Then pulse done_o and return to IDLE.
- Address arithmetic is modulo 2^ADDRW: a burst crossing the top of memory wraps to 0.
- Simultaneous events:
  - A FIFO push and pop in the same cycle keep the count unchanged.
  - A response and a new issue in the same cycle keep outstanding unchanged.
  - In combinational-SRAM mode, issue and response land in the same cycle.
- A mem_resp_i with outstanding == 0 is dropped and sets err_o. err_o clears only on reset.

## Timing
- Reset values: cmd_ready_o=0 during reset (IDLE afterwards → 1), all mem_* outputs 0, wready_o=0, rvalid_o=0, rdata_o=0, done_o=0, err_o=0.
- Reset asserted mid-burst aborts immediately: FIFO and counters clear, state → IDLE. Responses still in flight after reset count as spurious.
- Command accepted in cycle N → first mem_valid_o possible in cycle N+1.
- Sustained throughput is 1 beat/cycle:
  - writes: when wvalid_i is held high;
  - reads: with FIFO_DEPTH ≥ 2, a pipelined SRAM, and rready_i held high.
- rdata_o/rvalid_o are driven from FIFO registers, with no combinational path from mem_data_i.
- done_o fires one cycle after the completion condition is met. The next command can be accepted in the cycle after done_o.

## Structure
- Shared package mem_burst_pkg holds the state enum (IDLE/WRITE/READ/DRAIN) and a word-index helper (byte address → word address).
- Sub-module resp_fifo: synchronous FIFO, parameters DATAW and FIFO_DEPTH, push/pop/count/empty/full, asynchronous active-low reset.
- Counters: remaining (LENW+1 bits), outstanding and fifo_count ($clog2(FIFO_DEPTH)+1 bits).

## Test plan
- Write burst, addr 0x10, len 4, data 0xA0..0xA3, mask 0xF, pipelined SRAM → mem_addr_o = 0x10, 0x14, 0x18, 0x1C on consecutive cycles; done_o pulses 2 cycles after the last beat; readback matches.
- Read burst, addr 0x10, len 4, rready_i held 0 for 5 cycles → exactly 2 requests issued, then a stall; after rready_i=1, all 4 words arrive in order with no loss.
- Wrap: SIZE=1024, addr 0x3F8, len 4 → mem_addr_o = 0x3F8, 0x3FC, 0x000, 0x004.
- Combinational SRAM mode (resp in the same cycle), read len 8, rready_i=1 → 8 rdata beats in order, done_o pulses after the last pop, err_o=0.
- len=0 command → no mem_valid_o, done_o pulse next cycle. An unsolicited mem_resp_i in IDLE → err_o=1 and stays 1.
- rst_ni pulled low in mid-read burst (2 outstanding) → all outputs go to their reset values asynchronously. A new write burst after reset completes correctly.

Source files
------------

// File: rtl/mem_burst_pkg.sv
// mem_burst_pkg: burst-master state encoding and byte-to-word address helper
package mem_burst_pkg;
  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;
  function automatic int unsigned word_index(input int unsigned byte_addr, input int unsigned bytes_per_word);
    return byte_addr / bytes_per_word;
  endfunction
endpackage

// File: rtl/mem_burst_master_resp_fifo.sv
// resp_fifo: synchronous read-response FIFO with occupancy count
//   push/wdata  : enqueue one word
//   pop         : dequeue the head (caller guarantees not empty)
//   rdata       : head entry, forced to 0 while empty
//   count/empty/full : occupancy status
module resp_fifo #(
  parameter int DATAW = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          push,
  input  logic                          pop,
  input  logic [DATAW-1:0]              wdata,
  output logic [DATAW-1:0]              rdata,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          empty,
  output logic                          full
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  logic [DATAW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wp, rp;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(FIFO_DEPTH - 1) ? '0 : p + PW'(1);
  endfunction
  assign empty = count == '0;
  assign full = count == CW'(FIFO_DEPTH);
  assign rdata = empty ? '0 : mem[rp];
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (push) wp <= nxt(wp);
      if (pop) rp <= nxt(rp);
      count <= count + CW'(push) - CW'(pop);
    end
  always_ff @(posedge clk_i)
    if (push) mem[wp] <= wdata;
endmodule

// File: rtl/mem_burst_master.sv
// mem_burst_master: burst initiator between a command/stream interface and a single-port SRAM
//   cmd_*   : burst command (base byte address, beat count, direction)
//   w*      : write-data stream into the SRAM
//   r*      : read-data stream out of the response FIFO
//   mem_*   : SRAM request/response port (combinational or one-cycle read latency)
//   done_o  : one-cycle burst completion pulse; err_o : sticky spurious-response flag
module mem_burst_master
  import mem_burst_pkg::*;
#(
  parameter int SIZE = 1024,
  parameter int DATAW = 32,
  parameter int LENW = 8,
  parameter int FIFO_DEPTH = 2,
  parameter int ADDRW = $clog2(SIZE),
  parameter int MASKW = DATAW / 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic             cmd_we_i,
  input  logic [ADDRW-1:0] cmd_addr_i,
  input  logic [LENW-1:0]  cmd_len_i,
  input  logic [DATAW-1:0] wdata_i,
  input  logic [MASKW-1:0] wmask_i,
  input  logic             wvalid_i,
  output logic             wready_o,
  output logic [DATAW-1:0] rdata_o,
  output logic             rvalid_o,
  input  logic             rready_i,
  output logic [ADDRW-1:0] mem_addr_o,
  output logic [DATAW-1:0] mem_data_o,
  output logic [MASKW-1:0] mem_mask_o,
  output logic             mem_we_o,
  output logic             mem_valid_o,
  input  logic [DATAW-1:0] mem_data_i,
  input  logic             mem_resp_i,
  output logic             done_o,
  output logic             err_o
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  state_t state;
  logic live, we, done, err;
  logic [ADDRW-1:0] addr, aligned;
  logic [LENW:0] remaining;
  logic [CW-1:0] outstanding, count, out_n, count_n;
  logic issue, ok_resp, push, pop, empty, full, credit, accept, finish;
  assign aligned = ADDRW'(word_index(32'(cmd_addr_i), MASKW) * MASKW);
  // live keeps cmd_ready_o low while reset is asserted; done blocks a new command in the done cycle
  assign cmd_ready_o = live && state == IDLE && !done;
  assign accept = cmd_valid_i && cmd_ready_o;
  assign wready_o = state == WRITE;
  assign pop = rvalid_o && rready_i;
  // a read only goes out if a FIFO slot is already free for its data, counting this cycle's pop
  assign credit = !(full && !pop) && (outstanding + count - CW'(pop) < CW'(FIFO_DEPTH));
  assign issue = state == WRITE ? wvalid_i : state == READ && remaining != '0 && credit;
  assign mem_valid_o = issue;
  assign mem_we_o = wready_o;
  assign mem_addr_o = addr;
  assign mem_data_o = wready_o ? wdata_i : '0;
  assign mem_mask_o = wready_o ? wmask_i : '0;
  // a same-cycle issue makes a response legitimate even with nothing outstanding (combinational SRAM)
  assign ok_resp = mem_resp_i && (outstanding != '0 || issue);
  assign push = ok_resp && !we;
  assign out_n = outstanding + CW'(issue) - CW'(ok_resp);
  assign count_n = count + CW'(push) - CW'(pop);
  assign finish = out_n == '0 && (we || count_n == '0);
  assign done_o = done;
  assign err_o = err;
  assign rvalid_o = !empty;
  resp_fifo #(.DATAW(DATAW), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i(clk_i), .rst_ni(rst_ni), .push(push), .pop(pop), .wdata(mem_data_i),
    .rdata(rdata_o), .count(count), .empty(empty), .full(full)
  );
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state <= IDLE;
      live <= 1'b0;
      we <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      addr <= '0;
      remaining <= '0;
      outstanding <= '0;
    end else begin
      live <= 1'b1;
      done <= 1'b0;
      outstanding <= out_n;
      if (mem_resp_i && !ok_resp) err <= 1'b1;
      if (issue) begin
        addr <= addr + ADDRW'(MASKW);
        remaining <= remaining - (LENW+1)'(1);
      end
      case (state)
        IDLE: if (accept) begin
          we <= cmd_we_i;
          addr <= aligned;
          remaining <= {1'b0, cmd_len_i};
          if (cmd_len_i == '0) done <= 1'b1;
          else state <= cmd_we_i ? WRITE : READ;
        end
        WRITE, READ: if (issue && remaining == (LENW+1)'(1)) state <= DRAIN;
        DRAIN: if (finish) begin
          state <= IDLE;
          done <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
endmodule
